// File: rtl/cac_command_sequencer_if.sv
// Byte-stream and settings-memory signals of the CAC command sequencer.
// master = sequencer side, slave = UART buffers / settings ROM and RAM side.
interface cac_command_sequencer_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_error;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  ram_we;
  logic                  ram_re;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [7:0]            ram_wdata;
  logic [7:0]            ram_rdata;
  logic                  rom_re;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [7:0]            rom_rdata;

  // tx: tx_valid/tx_data held stable until the cycle tx_valid & tx_ready are both 1.
  // rx: rx_valid and rx_error are single-cycle strobes with no backpressure.
  modport master (
    input  rx_data, rx_valid, rx_error, tx_ready, ram_rdata, rom_rdata,
    output tx_data, tx_valid, ram_we, ram_re, ram_addr, ram_wdata, rom_re, rom_addr
  );

  modport slave (
    output rx_data, rx_valid, rx_error, tx_ready, ram_rdata, rom_rdata,
    input  tx_data, tx_valid, ram_we, ram_re, ram_addr, ram_wdata, rom_re, rom_addr
  );
endinterface

// File: rtl/cac_command_sequencer.sv
// Parses 5-byte command frames (A5 CMD ADDR DATA CHK), runs a RAM write, RAM read
// or ROM read, and answers with a 4-byte response frame (5A STATUS DATA RCHK).
module cac_command_sequencer #(
  parameter int ADDR_WIDTH     = 8,
  parameter int ROM_LENGTH     = 16,
  parameter int RAM_LENGTH     = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk_cac,
  input  logic                  rst_cac,
  cac_command_sequencer_if.master bus,
  output logic                  busy,
  output logic [7:0]            err_count,
  output logic [3:0]            state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE, S_R_CMD, S_R_ADDR, S_R_DATA, S_R_CHK, S_EXEC, S_RD_WAIT,
    S_T_HDR, S_T_STAT, S_T_DATA, S_T_CHK
  } state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state_q, state_d;
  logic [7:0]    cmd_q, addr_q, data_q, chk_q;
  logic [7:0]    status_q, resp_q, err_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    exec_status;
  logic          cmd_ok, addr_ok, in_rx, byte_in, tmo_hit, err_evt;

  assign in_rx   = (state_q == S_R_CMD) || (state_q == S_R_ADDR) ||
                   (state_q == S_R_DATA) || (state_q == S_R_CHK);
  // a simultaneous rx_error discards the byte
  assign byte_in = bus.rx_valid && !bus.rx_error;
  // counter reaches TIMEOUT_CYCLES-1 on this edge with no byte arriving
  assign tmo_hit = in_rx && !bus.rx_valid && (tmo_q == TW'(TIMEOUT_CYCLES - 2));

  assign cmd_ok  = (cmd_q == 8'h01) || (cmd_q == 8'h02) || (cmd_q == 8'h03);
  assign addr_ok = (cmd_q == 8'h03) ? ({24'd0, addr_q} < 32'(ROM_LENGTH))
                                    : ({24'd0, addr_q} < 32'(RAM_LENGTH));

  always_comb begin
    exec_status = 8'h00;
    if (chk_q != (cmd_q ^ addr_q ^ data_q)) exec_status = 8'h01;
    else if (!cmd_ok)                       exec_status = 8'h02;
    else if (!addr_ok)                      exec_status = 8'h03;
  end

  // state register
  always_ff @(posedge clk_cac) begin
    if (rst_cac) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    err_evt = 1'b0;
    case (state_q)
      S_IDLE: if (byte_in && bus.rx_data == 8'hA5) state_d = S_R_CMD;
      S_R_CMD, S_R_ADDR, S_R_DATA, S_R_CHK: begin
        if (bus.rx_error || tmo_hit) begin
          state_d = S_IDLE;
          err_evt = 1'b1;
        end else if (bus.rx_valid) begin
          case (state_q)
            S_R_CMD:  state_d = S_R_ADDR;
            S_R_ADDR: state_d = S_R_DATA;
            S_R_DATA: state_d = S_R_CHK;
            default:  state_d = S_EXEC;
          endcase
        end
      end
      S_EXEC: begin
        err_evt = (exec_status != 8'h00);
        state_d = (exec_status == 8'h00 && cmd_q != 8'h01) ? S_RD_WAIT : S_T_HDR;
      end
      S_RD_WAIT: state_d = S_T_HDR;
      S_T_HDR:   if (bus.tx_ready) state_d = S_T_STAT;
      S_T_STAT:  if (bus.tx_ready) state_d = S_T_DATA;
      S_T_DATA:  if (bus.tx_ready) state_d = S_T_CHK;
      S_T_CHK:   if (bus.tx_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // frame fields, response registers, timeout and error counters
  always_ff @(posedge clk_cac) begin
    if (rst_cac) begin
      cmd_q    <= 8'h00;
      addr_q   <= 8'h00;
      data_q   <= 8'h00;
      chk_q    <= 8'h00;
      status_q <= 8'h00;
      resp_q   <= 8'h00;
      err_q    <= 8'h00;
      tmo_q    <= '0;
    end else begin
      if (byte_in) begin
        case (state_q)
          S_R_CMD:  cmd_q  <= bus.rx_data;
          S_R_ADDR: addr_q <= bus.rx_data;
          S_R_DATA: data_q <= bus.rx_data;
          S_R_CHK:  chk_q  <= bus.rx_data;
          default:  ;
        endcase
      end
      if (state_q == S_EXEC) begin
        status_q <= exec_status;
        resp_q   <= (exec_status == 8'h00 && cmd_q == 8'h01) ? data_q : 8'h00;
      end
      if (state_q == S_RD_WAIT)
        resp_q <= (cmd_q == 8'h03) ? bus.rom_rdata : bus.ram_rdata;
      if (err_evt && err_q != 8'hFF) err_q <= err_q + 8'd1;
      if (!in_rx || bus.rx_valid) tmo_q <= '0;
      else                        tmo_q <= tmo_q + TW'(1);
    end
  end

  // outputs
  always_comb begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    bus.ram_we   = 1'b0;
    bus.ram_re   = 1'b0;
    bus.rom_re   = 1'b0;
    case (state_q)
      S_EXEC: begin
        bus.ram_we = (exec_status == 8'h00) && (cmd_q == 8'h01);
        bus.ram_re = (exec_status == 8'h00) && (cmd_q == 8'h02);
        bus.rom_re = (exec_status == 8'h00) && (cmd_q == 8'h03);
      end
      S_T_HDR:  begin bus.tx_valid = 1'b1; bus.tx_data = 8'h5A;             end
      S_T_STAT: begin bus.tx_valid = 1'b1; bus.tx_data = status_q;          end
      S_T_DATA: begin bus.tx_valid = 1'b1; bus.tx_data = resp_q;            end
      S_T_CHK:  begin bus.tx_valid = 1'b1; bus.tx_data = status_q ^ resp_q; end
      default:  ;
    endcase
  end

  assign bus.ram_addr  = ADDR_WIDTH'(addr_q);
  assign bus.rom_addr  = ADDR_WIDTH'(addr_q);
  assign bus.ram_wdata = data_q;
  assign busy          = (state_q != S_IDLE);
  assign err_count     = err_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_cac_command_sequencer.sv
// Randomized bench for cac_command_sequencer: frames are scored against a
// frame-level model of the settings memories, status rules and error counter.
module tb_cac_command_sequencer;

  localparam int RAM_LEN = 16;
  localparam int ROM_LEN = 16;
  localparam int TMO     = 50;

  logic       clk, rst, busy;
  logic [7:0] err_count;
  logic [3:0] state_dbg;

  cac_command_sequencer_if #(.ADDR_WIDTH(8)) bus ();

  cac_command_sequencer #(
    .ADDR_WIDTH(8), .ROM_LENGTH(ROM_LEN), .RAM_LENGTH(RAM_LEN), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_cac(clk), .rst_cac(rst), .bus(bus.master),
    .busy(busy), .err_count(err_count), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int bp_mode  = 0;
  int stab_viol = 0, strobe_viol = 0, strobe_cnt = 0, exp_strobe = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] model_ram[256];
  logic [7:0] tb_mem[256];
  logic [7:0] exp_err = 8'h00;

  function automatic logic [7:0] rom_val(input logic [7:0] a);
    rom_val = (a * 8'h13) ^ 8'h37;
  endfunction

  // settings memories: one-cycle read latency
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= 8'h00;
    end else begin
      if (bus.ram_we) tb_mem[bus.ram_addr] <= bus.ram_wdata;
      if (bus.ram_re) bus.ram_rdata <= tb_mem[bus.ram_addr];
      if (bus.rom_re) bus.rom_rdata <= rom_val(bus.rom_addr);
    end
  end

  // tx_ready: random, or held low 10 cycles per presented byte
  always @(posedge clk) begin
    static int wc = 0;
    #1;
    if (bp_mode == 0) begin
      bus.tx_ready = ($urandom_range(0, 3) != 0);
      wc = 0;
    end else if (!bus.tx_valid) begin
      bus.tx_ready = 1'b0; wc = 0;
    end else if (wc < 10) begin
      bus.tx_ready = 1'b0; wc++;
    end else begin
      bus.tx_ready = 1'b1; wc = 0;
    end
  end

  // monitor: collect handshaken bytes, hold stability, strobe rules
  always @(negedge clk) begin
    static bit         prev_pending = 0;
    static bit         prev_strobe  = 0;
    static logic [7:0] prev_data    = 8'h00;
    int n;
    if (rst) begin
      prev_pending = 0;
      prev_strobe  = 0;
    end else begin
      if (bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_data);
      if (prev_pending && (!bus.tx_valid || bus.tx_data != prev_data)) stab_viol++;
      prev_pending = bus.tx_valid && !bus.tx_ready;
      prev_data    = bus.tx_data;
      n = int'(bus.ram_we) + int'(bus.ram_re) + int'(bus.rom_re);
      if (n > 1 || (n != 0 && prev_strobe)) strobe_viol++;
      prev_strobe = (n != 0);
      strobe_cnt += n;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick(1);
    bus.rx_valid = 1'b0;
  endtask

  task automatic gap();
    tick($urandom_range(0, 2));
  endtask

  task automatic model_frame(input logic [7:0] cmd, addr, data, chk,
                             output logic [7:0] st, output logic [7:0] d);
    int lim;
    lim = (cmd == 8'h03) ? ROM_LEN : RAM_LEN;
    if (chk != (cmd ^ addr ^ data))        st = 8'h01;
    else if (cmd < 8'h01 || cmd > 8'h03)   st = 8'h02;
    else if (int'(addr) >= lim)            st = 8'h03;
    else                                   st = 8'h00;
    d = 8'h00;
    if (st == 8'h00) begin
      if (cmd == 8'h01) begin model_ram[addr] = data; d = data; end
      else if (cmd == 8'h02) d = model_ram[addr];
      else d = rom_val(addr);
    end else if (exp_err != 8'hFF) exp_err++;
    exp_q.push_back(8'h5A);
    exp_q.push_back(st);
    exp_q.push_back(d);
    exp_q.push_back(st ^ d);
  endtask

  // sends a frame and checks the execute cycle and first response latency
  task automatic issue_frame(input logic [7:0] cmd, addr, data, chk);
    logic [7:0] st, d;
    model_frame(cmd, addr, data, chk, st, d);
    exp_strobe = (st == 8'h00) ? 1 : 0;
    strobe_cnt = 0;
    send_byte(8'hA5); gap();
    send_byte(cmd);   gap();
    send_byte(addr);  gap();
    send_byte(data);  gap();
    send_byte(chk);
    check_eq("exec_ram_we", bus.ram_we, (st == 8'h00 && cmd == 8'h01));
    check_eq("exec_ram_re", bus.ram_re, (st == 8'h00 && cmd == 8'h02));
    check_eq("exec_rom_re", bus.rom_re, (st == 8'h00 && cmd == 8'h03));
    if (st == 8'h00 && cmd != 8'h03) check_eq("ram_addr", bus.ram_addr, addr);
    if (st == 8'h00 && cmd == 8'h03) check_eq("rom_addr", bus.rom_addr, addr);
    if (st == 8'h00 && cmd == 8'h01) check_eq("ram_wdata", bus.ram_wdata, data);
    check_eq("exec_tx_valid", bus.tx_valid, 0);
    tick(1);
    if (st == 8'h00 && cmd != 8'h01) begin
      check_eq("rd_wait_tx_valid", bus.tx_valid, 0);
      tick(1);
    end
    check_eq("first_tx_valid", bus.tx_valid, 1);
  endtask

  // waits for the response to drain and scores it
  task automatic finish_frame(input string tag);
    int n = 0;
    while (busy && n < 1000) begin tick(1); n++; end
    check_eq({tag, "_done"}, busy, 0);
    check_eq({tag, "_len"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check_eq({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
    check_eq({tag, "_strobes"}, strobe_cnt, exp_strobe);
    check_eq({tag, "_err_count"}, err_count, exp_err);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 256; i++) model_ram[i] = 8'h00;
    exp_err = 8'h00;
    tick(1);
  endtask

  initial begin
    logic [7:0] cmd, addr, data, chk;
    int sel;
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.rx_error = 1'b0; bus.tx_ready = 1'b0;
    rst = 1'b1;
    tick(2);
    do_reset();
    check_eq("rst_tx_valid", bus.tx_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err_count", err_count, 0);
    check_eq("rst_strobes", {bus.ram_we, bus.ram_re, bus.rom_re}, 0);
    check_eq("rst_tx_data", bus.tx_data, 0);
    check_eq("rst_ram_addr", bus.ram_addr, 0);
    rst = 1'b0;
    tick(2);

    // write, read-back, ROM read
    issue_frame(8'h01, 8'h03, 8'h7E, 8'h7C); finish_frame("write");
    issue_frame(8'h02, 8'h03, 8'h00, 8'h01); finish_frame("readback");
    issue_frame(8'h03, 8'h02, 8'h00, 8'h01); finish_frame("rom_read");

    // rejected frames
    issue_frame(8'h01, 8'h03, 8'h7E, 8'h00); finish_frame("bad_chk");
    issue_frame(8'h07, 8'h00, 8'h00, 8'h07); finish_frame("bad_cmd");
    issue_frame(8'h02, 8'h20, 8'h00, 8'h22); finish_frame("bad_addr");
    issue_frame(8'h03, 8'h10, 8'h00, 8'h13); finish_frame("bad_rom_addr");

    // backpressure with stray bytes during the response
    bp_mode = 1;
    issue_frame(8'h02, 8'h03, 8'h00, 8'h01);
    send_byte(8'h33); tick(1); send_byte(8'hA5);
    check_eq("stray_busy", busy, 1);
    finish_frame("backpressure");
    bp_mode = 0;
    tick(5);
    check_eq("stray_no_frame_busy", busy, 0);
    check_eq("stray_no_tx", got_q.size(), 0);

    // inter-byte timeout
    send_byte(8'hA5); send_byte(8'h01);
    tick(TMO - 3);
    check_eq("tmo_still_busy", busy, 1);
    tick(3);
    exp_err++;
    check_eq("tmo_idle", busy, 0);
    check_eq("tmo_err_count", err_count, exp_err);
    check_eq("tmo_no_tx", got_q.size(), 0);

    // rx_error abort, with a simultaneous byte that must be dropped
    send_byte(8'hA5); send_byte(8'h01);
    bus.rx_error = 1'b1; bus.rx_valid = 1'b1; bus.rx_data = 8'h03;
    tick(1);
    bus.rx_error = 1'b0; bus.rx_valid = 1'b0;
    exp_err++;
    check_eq("abort_idle", busy, 0);
    check_eq("abort_err_count", err_count, exp_err);
    bus.rx_error = 1'b1; tick(1); bus.rx_error = 1'b0;
    send_byte(8'h00); send_byte(8'hFF);
    tick(3);
    check_eq("idle_garbage_busy", busy, 0);
    check_eq("idle_garbage_err", err_count, exp_err);
    check_eq("idle_garbage_tx", got_q.size(), 0);

    // reset while a response byte waits for tx_ready
    bp_mode = 1;
    issue_frame(8'h02, 8'h05, 8'h00, 8'h07);
    tick(2);
    check_eq("pre_rst_tx_valid", bus.tx_valid, 1);
    do_reset();
    check_eq("mid_rst_tx_valid", bus.tx_valid, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_err_count", err_count, 0);
    rst = 1'b0;
    bp_mode = 0;
    got_q.delete();
    exp_q.delete();
    tick(2);
    issue_frame(8'h01, 8'h09, 8'hC3, 8'h01 ^ 8'h09 ^ 8'hC3); finish_frame("post_rst");

    // randomized frames
    for (int k = 0; k < 40; k++) begin
      sel  = $urandom_range(0, 9);
      cmd  = (sel < 4) ? 8'h01 : (sel < 7) ? 8'h02 : (sel < 9) ? 8'h03 : 8'($urandom_range(0, 255));
      addr = 8'($urandom_range(0, 19));
      data = 8'($urandom_range(0, 255));
      chk  = cmd ^ addr ^ data;
      if ($urandom_range(0, 6) == 0) chk = chk ^ 8'($urandom_range(1, 255));
      issue_frame(cmd, addr, data, chk);
      finish_frame("random");
    end

    check_eq("tx_hold_stable", stab_viol, 0);
    check_eq("strobe_exclusive_1cycle", strobe_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cac_command_sequencer.md
Name: cac_command_sequencer

Overview:
- Frame-level controller between the CAC UART byte stream and the settings memories: parses 5-byte command frames from UART RX, executes RAM write, RAM read or ROM read, and returns a 4-byte response frame over UART TX.
- Sits inside communication_and_control in the clk_cac domain, between the UART RX/TX buffers and the settings ROM/RAM.

Parameters:
ADDR_WIDTH, 8, settings address width; frame ADDR byte zero-extended/truncated to this
ROM_LENGTH, 16, valid ROM addresses 0..ROM_LENGTH-1
RAM_LENGTH, 16, valid RAM addresses 0..RAM_LENGTH-1
TIMEOUT_CYCLES, 100000, max clk_cac cycles between bytes of one frame

Ports:
clk_cac  in  1  block clock
rst_cac  in  1  synchronous, active-high reset
rx_data  in  8  received byte
rx_valid  in  1  single-cycle strobe, rx_data valid
rx_error  in  1  single-cycle UART framing/parity error strobe
tx_data  out  8  byte to transmit
tx_valid  out  1  tx_data valid; held until tx_ready
tx_ready  in  1  UART TX accepts byte when tx_valid&tx_ready
ram_we  out  1  one-cycle RAM write strobe
ram_re  out  1  one-cycle RAM read strobe
ram_addr  out  ADDR_WIDTH  RAM address
ram_wdata  out  8  RAM write data
ram_rdata  in  8  RAM read data, valid 1 cycle after ram_re
rom_re  out  1  one-cycle ROM read strobe
rom_addr  out  ADDR_WIDTH  ROM address
rom_rdata  in  8  ROM read data, valid 1 cycle after rom_re
busy  out  1  high in every state except IDLE
err_count  out  8  saturating count of rejected/aborted frames

Behaviour:
- Reset (rst_cac=1 at a clk_cac edge): state IDLE; tx_valid, ram_we, ram_re, rom_re, busy = 0; tx_data, ram_addr, ram_wdata, rom_addr = 0; err_count = 0; timeout counter = 0. Applies mid-frame and mid-response; a pending tx_valid drops with no handshake.
- Command frame: 0xA5, CMD, ADDR, DATA, CHK, with CHK = CMD^ADDR^DATA. CMD 0x01 = RAM write, 0x02 = RAM read, 0x03 = ROM read. DATA is ignored for reads but still checksummed.
- States: IDLE -> R_CMD -> R_ADDR -> R_DATA -> R_CHK -> EXEC -> RD_WAIT (reads only) -> T_HDR -> T_STAT -> T_DATA -> T_CHK -> IDLE.
- IDLE: a byte other than 0xA5 is discarded silently with no error count. 0xA5 -> R_CMD.
- Each R_* state captures rx_data on rx_valid and advances.
- EXEC, single cycle, checks in priority order: checksum mismatch -> STATUS 0x01; CMD not in {01,02,03} -> 0x02; address >= RAM_LENGTH (RAM commands) or >= ROM_LENGTH (ROM read) -> 0x03; otherwise 0x00.
  - OK write: ram_we=1 for exactly this cycle with ram_addr/ram_wdata; response DATA = written byte.
  - OK read: ram_re or rom_re=1 for this cycle; RD_WAIT captures rdata on the next cycle.
  - Any error: no memory strobe, response DATA=0x00, err_count+1 (saturates at 0xFF).
- Response frame: 0x5A, STATUS, DATA, RCHK = STATUS^DATA.
  - Each byte is presented with tx_valid=1 and tx_data stable until the cycle tx_valid&tx_ready=1; the next byte is presented the following cycle.
  - tx_valid drops after the RCHK handshake; return to IDLE.
- Latency: EXEC follows the CHK byte by 1 cycle. First tx_valid appears 1 cycle after EXEC for writes/errors, 2 cycles for reads.
- Timeout: in R_CMD..R_CHK the counter increments each cycle and clears on rx_valid. At TIMEOUT_CYCLES-1 without a byte: -> IDLE, err_count+1, no response.
- rx_error in R_CMD..R_CHK aborts to IDLE with err_count+1. rx_error in IDLE is ignored.
- rx_valid and rx_error in the same cycle: rx_error wins, and the byte is dropped.
- rx_valid during EXEC, RD_WAIT or T_*: byte dropped, no error count. The next frame must begin after the return to IDLE.
- Only one of ram_we/ram_re/rom_re is ever high, never for more than 1 cycle.

Test Plan:
- Write: A5 01 03 7E 7C -> ram_we pulse with addr=3, wdata=0x7E; response 5A 00 7E 7E; err_count=0.
- Read-back: after the write, A5 02 03 00 01 -> ram_re 1 cycle, ram_rdata=0x7E returned; response 5A 00 7E 7E. ROM read A5 03 02 00 01 with rom_rdata=0x11 -> 5A 00 11 11.
- Errors: A5 01 03 7E 00 -> 5A 01 00 01, no ram_we; A5 07 00 00 07 -> 5A 02 00 02; A5 02 20 00 22 (RAM_LENGTH=16) -> 5A 03 00 03; err_count=3.
- Backpressure: tx_ready low 10 cycles per byte during a read response -> each byte held stable, no byte lost or duplicated; stray bytes 0x33 0xA5 sent during the response are dropped, and busy stays 1 until after RCHK.
- Timeout/abort: A5 01 then silence for TIMEOUT_CYCLES (set to 50) -> IDLE at cycle 49, no tx_valid, err_count+1. A5 01 plus an rx_error strobe -> IDLE, err_count+1. Garbage 0x00 0xFF in IDLE -> no count, no response.
- Reset mid-response: rst_cac high while tx_valid=1 awaiting tx_ready -> next edge: tx_valid=0, busy=0, err_count=0. A full valid frame afterwards completes normally.
